// File: rtl/aes128_decryptor.sv
// rtl/aes128_decryptor.sv - iterative AES-128 inverse cipher, one round per clock, on-the-fly round keys
// Optional AES_DEC_KEY_CACHE_EN keeps round key 10 so a reused key skips the forward schedule.
module aes128_decryptor #(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] ciphertext_i,
  input  logic [WIDTH-1:0] key_i,
  input  logic             data_valid_i,
  input  logic             key_valid_i,
  output logic             data_ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] plaintext_o,
  output logic             plaintext_valid_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEXP  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return 8'(({1'b0, x} ^ (x[0] ? 9'h11b : 9'h000)) >> 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (zero maps to zero).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x240 = gf_mul(x12, x3);
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ g_word(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a1, a2, a3;
    a3 = k[31:0] ^ k[63:32];
    a2 = k[63:32] ^ k[95:64];
    a1 = k[95:64] ^ k[127:96];
    return {k[127:96] ^ g_word(a3, rc), a1, a2, a3};
  endfunction

  // Byte k of the block sits at [127-8k -: 8], column-major (k = col*4 + row).
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = inv_sbox(s[127-8*(((c-r+4)%4)*4+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q, key_d, rk_q, rk_d, st_q, st_d, pt_q, pt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         pt_vld_q, pt_vld_d;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_q, cache_d;
  logic         cache_vld_q, cache_vld_d;
`endif

  logic [127:0] rk_fwd, rk_inv, core;
  assign rk_fwd = key_fwd(rk_q, rcon_q);
  assign rk_inv = key_inv(rk_q, rcon_q);
  assign core   = inv_sub_shift(st_q);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    rk_d     = rk_q;
    st_d     = st_q;
    rcon_d   = rcon_q;
    cnt_d    = cnt_q;
    pt_d     = pt_q;
    pt_vld_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_valid_i) begin
          if (key_valid_i) key_d = key_i;
          rk_d    = key_valid_i ? key_i : key_q;
          rcon_d  = 8'h01;
          cnt_d   = 4'd0;
          st_d    = ciphertext_i;
          state_d = S_KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (key_valid_i) begin
            cache_vld_d = 1'b0;
          end else if (cache_vld_q) begin
            rk_d    = cache_q;
            st_d    = ciphertext_i ^ cache_q;
            rcon_d  = 8'h36;
            cnt_d   = 4'd9;
            state_d = S_ROUND;
          end
`endif
        end
      end
      S_KEXP: begin
        rk_d   = rk_fwd;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          st_d    = st_q ^ rk_fwd;
          rcon_d  = 8'h36;
          cnt_d   = 4'd9;
          state_d = S_ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_d     = rk_fwd;
          cache_vld_d = 1'b1;
`endif
        end
      end
      S_ROUND: begin
        // cnt_q is the round index r; rk_q holds rk_{r+1} and rk_inv is rk_r.
        rk_d   = rk_inv;
        rcon_d = inv_xtime(rcon_q);
        if (cnt_q == 4'd0) begin
          pt_d     = core ^ rk_inv;
          pt_vld_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          st_d  = inv_mix(core ^ rk_inv);
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      rk_q     <= '0;
      st_q     <= '0;
      rcon_q   <= '0;
      cnt_q    <= '0;
      pt_q     <= '0;
      pt_vld_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      rk_q     <= rk_d;
      st_q     <= st_d;
      rcon_q   <= rcon_d;
      cnt_q    <= cnt_d;
      pt_q     <= pt_d;
      pt_vld_q <= pt_vld_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  assign data_ready_o      = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign plaintext_o       = pt_q;
  assign plaintext_valid_o = pt_vld_q;
endmodule

// File: tb/tb_aes128_decryptor.sv
// tb/tb_aes128_decryptor.sv - scoreboard bench for aes128_decryptor using FIPS-197 vectors
// Reuse latency expectation follows AES_DEC_KEY_CACHE_EN.
module tb_aes128_decryptor;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int REUSE_LAT = 11;
`else
  localparam int REUSE_LAT = 21;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key_in = '0;
  logic         data_valid = 1'b0;
  logic         key_valid = 1'b0;
  logic         data_ready, busy, pt_valid;
  logic [127:0] pt;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  int acc_cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_v;

  aes128_decryptor #(.WIDTH(128)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ciphertext_i(ct), .key_i(key_in),
    .data_valid_i(data_valid), .key_valid_i(key_valid),
    .data_ready_o(data_ready), .busy_o(busy),
    .plaintext_o(pt), .plaintext_valid_o(pt_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pt_valid) begin
    n_valid++;
    last_valid_cyc = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [127:0] c, input logic [127:0] k, input logic kv, input logic [127:0] e);
    @(negedge clk); #1;
    ct = c; key_in = k; key_valid = kv; data_valid = 1'b1;
    acc_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk); #1;
    data_valid = 1'b0; key_valid = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int start;
    start = n_valid;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_valid != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    compared++; if (data_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (pt !== 128'h0) begin mismatched++; $display("FAIL reset_pt: got %h want 0", pt); end
    compared++; if (pt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", pt_valid); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_c1;
    bit ok;
    send(C1_CT, C1_KEY, 1'b1, C1_PT);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL c1_busy: got %b want 1", busy); end
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL c1_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL c1_pt: got %h want %h", pt, exp_v); end
    compared++; if (last_valid_cyc - acc_cyc !== 21) begin mismatched++; $display("FAIL c1_latency: got %0d want 21", last_valid_cyc - acc_cyc); end
    compared++; if (data_ready !== 1'b1) begin mismatched++; $display("FAIL c1_ready_with_valid: got %b want 1", data_ready); end
  endtask

  task automatic test_fips_b;
    bit ok;
    send(B_CT, B_KEY, 1'b1, B_PT);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    compared++; if (dut.rk_q !== B_RK10) begin mismatched++; $display("FAIL b_rk10: got %h want %h", dut.rk_q, B_RK10); end
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL b_pt: got %h want %h", pt, exp_v); end
    compared++; if (last_valid_cyc - acc_cyc !== 21) begin mismatched++; $display("FAIL b_latency: got %0d want 21", last_valid_cyc - acc_cyc); end
  endtask

  task automatic test_key_reuse;
    bit ok;
    send(B_CT, {$urandom, $urandom, $urandom, $urandom}, 1'b0, B_PT);
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL reuse_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL reuse_pt: got %h want %h", pt, exp_v); end
    compared++; if (last_valid_cyc - acc_cyc !== REUSE_LAT) begin mismatched++; $display("FAIL reuse_latency: got %0d want %0d", last_valid_cyc - acc_cyc, REUSE_LAT); end
  endtask

  task automatic test_busy_drop;
    bit ok;
    int start;
    start = n_valid;
    send(C1_CT, C1_KEY, 1'b1, C1_PT);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    ct = 128'h0; key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1; data_valid = 1'b1;
    @(negedge clk); #1;
    data_valid = 1'b0; key_valid = 1'b0;
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL drop_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL drop_pt: got %h want %h", pt, exp_v); end
    compared++; if (last_valid_cyc - acc_cyc !== 21) begin mismatched++; $display("FAIL drop_latency: got %0d want 21", last_valid_cyc - acc_cyc); end
    for (int i = 0; i < 30; i++) @(negedge clk);
    #1;
    compared++; if (n_valid - start !== 1) begin mismatched++; $display("FAIL drop_pulses: got %0d want 1", n_valid - start); end
  endtask

  task automatic test_reset_midop;
    bit ok;
    int start;
    send(C1_CT, C1_KEY, 1'b1, C1_PT);
    for (int i = 0; i < 11; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (pt !== 128'h0) begin mismatched++; $display("FAIL midrst_pt: got %h want 0", pt); end
    compared++; if (pt_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b want 0", pt_valid); end
    compared++; if (data_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b want 1", data_ready); end
    void'(exp_q.pop_front());
    start = n_valid;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) @(negedge clk);
    #1;
    compared++; if (n_valid !== start) begin mismatched++; $display("FAIL midrst_stray_valid: got %0d pulses want 0", n_valid - start); end
    send(C1_CT, C1_KEY, 1'b1, C1_PT);
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL midrst_fresh_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL midrst_fresh_pt: got %h want %h", pt, exp_v); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int first_cyc;
    @(negedge clk); #1;
    ct = C1_CT; key_in = C1_KEY; key_valid = 1'b1; data_valid = 1'b1;
    acc_cyc = cyc;
    exp_q.push_back(C1_PT);
    exp_q.push_back(C1_PT);
    wait_valid(40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_first_timeout: no valid within 40 cycles"); end
    first_cyc = last_valid_cyc;
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL b2b_first_pt: got %h want %h", pt, exp_v); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
    @(negedge clk); #1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_rebusy: got %b want 1", busy); end
    wait_valid(40, ok);
    data_valid = 1'b0; key_valid = 1'b0;
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_second_timeout: no valid within 40 cycles"); end
    exp_v = exp_q.pop_front();
    compared++; if (pt !== exp_v) begin mismatched++; $display("FAIL b2b_second_pt: got %h want %h", pt, exp_v); end
    compared++; if (last_valid_cyc - first_cyc !== 21) begin mismatched++; $display("FAIL b2b_spacing: got %0d want 21", last_valid_cyc - first_cyc); end
  endtask

  initial begin
    test_reset;
    test_fips_c1;
    test_fips_b;
    test_key_reuse;
    test_busy_drop;
    test_reset_midop;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
